// File: rtl/mac_lookup_ctrl_if.sv
// rtl/mac_lookup_ctrl_if.sv - ingress, address_table and decision signals of mac_lookup_ctrl
interface mac_lookup_ctrl_if #(
  parameter int PORT_W = 2
) ();
  logic              in_valid_i;
  logic              in_ready_o;
  logic [7:0]        in_data_i;
  logic              in_last_i;
  logic [PORT_W-1:0] in_port_i;

  logic              learn_req_o;
  logic [47:0]       learn_address_o;
  logic [PORT_W-1:0] learn_port_o;

  logic              read_req_o;
  logic [47:0]       read_address_o;
  logic [PORT_W-1:0] read_port_i;
  logic              read_port_valid_i;

  logic              dec_valid_o;
  logic              dec_ready_i;
  logic [PORT_W-1:0] dec_port_o;
  logic              dec_flood_o;
  logic              dec_drop_o;

  // Header front-end side
  modport slave (
    input  in_valid_i, in_data_i, in_last_i, in_port_i,
    input  read_port_i, read_port_valid_i, dec_ready_i,
    output in_ready_o, learn_req_o, learn_address_o, learn_port_o,
    output read_req_o, read_address_o,
    output dec_valid_o, dec_port_o, dec_flood_o, dec_drop_o
  );

  // Ingress mux / address_table / queue manager side
  modport master (
    output in_valid_i, in_data_i, in_last_i, in_port_i,
    output read_port_i, read_port_valid_i, dec_ready_i,
    input  in_ready_o, learn_req_o, learn_address_o, learn_port_o,
    input  read_req_o, read_address_o,
    input  dec_valid_o, dec_port_o, dec_flood_o, dec_drop_o
  );
endinterface

// File: rtl/mac_lookup_ctrl.sv
// rtl/mac_lookup_ctrl.sv - MAC header capture, learn/lookup requests and forwarding decision
module mac_lookup_ctrl #(
  parameter int NUM_PORTS = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  mac_lookup_ctrl_if.slave bus,
  output logic [CNT_W-1:0] runt_cnt_o
);
  localparam int PORT_W = $clog2(NUM_PORTS);

  typedef enum logic [2:0] {
    S_HDR,
    S_LEARN,
    S_LOOKUP,
    S_WAIT_RSP,
    S_DECIDE,
    S_DRAIN
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        byte_cnt_q;
  logic [47:0]       dst_q, src_q;
  logic [PORT_W-1:0] in_port_q;
  logic              eof_seen_q;
  logic [PORT_W-1:0] dec_port_q;
  logic              dec_flood_q, dec_drop_q;
  logic [CNT_W-1:0]  runt_cnt_q;

  logic in_ready, learn_req, read_req, dec_valid;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_HDR;
    else     state_q <= state_d;
  end

  // Next state and per-state strobes; the header state is always ready so
  // in_valid_i alone marks an accepted byte there.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    learn_req = 1'b0;
    read_req  = 1'b0;
    dec_valid = 1'b0;
    case (state_q)
      S_HDR: begin
        in_ready = 1'b1;
        if (bus.in_valid_i && byte_cnt_q == 4'd11) state_d = S_LEARN;
      end
      S_LEARN: begin
        learn_req = !src_q[40];
        state_d   = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (dst_q[40]) begin
          state_d = S_DECIDE;
        end else begin
          read_req = 1'b1;
          state_d  = S_WAIT_RSP;
        end
      end
      S_WAIT_RSP: state_d = S_DECIDE;
      S_DECIDE: begin
        dec_valid = 1'b1;
        if (bus.dec_ready_i) state_d = eof_seen_q ? S_HDR : S_DRAIN;
      end
      S_DRAIN: begin
        in_ready = 1'b1;
        if (bus.in_valid_i && bus.in_last_i) state_d = S_HDR;
      end
      default: state_d = S_HDR;
    endcase
  end

  // Header capture, runt counting and decision registers
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt_q  <= 4'd0;
      dst_q       <= 48'd0;
      src_q       <= 48'd0;
      in_port_q   <= '0;
      eof_seen_q  <= 1'b0;
      dec_port_q  <= '0;
      dec_flood_q <= 1'b0;
      dec_drop_q  <= 1'b0;
      runt_cnt_q  <= '0;
    end else begin
      case (state_q)
        S_HDR: begin
          if (bus.in_valid_i) begin
            if (byte_cnt_q == 4'd0) in_port_q <= bus.in_port_i;
            if (byte_cnt_q < 4'd6) dst_q <= {dst_q[39:0], bus.in_data_i};
            else                   src_q <= {src_q[39:0], bus.in_data_i};
            if (byte_cnt_q == 4'd11) begin
              byte_cnt_q <= 4'd0;
              eof_seen_q <= bus.in_last_i;
            end else if (bus.in_last_i) begin
              byte_cnt_q <= 4'd0;
              if (runt_cnt_q != {CNT_W{1'b1}}) runt_cnt_q <= runt_cnt_q + CNT_W'(1);
            end else begin
              byte_cnt_q <= byte_cnt_q + 4'd1;
            end
          end
        end
        S_LOOKUP: begin
          // Group destinations (including broadcast) flood without a lookup
          if (dst_q[40]) begin
            dec_port_q  <= '0;
            dec_flood_q <= 1'b1;
            dec_drop_q  <= 1'b0;
          end
        end
        S_WAIT_RSP: begin
          if (!bus.read_port_valid_i) begin
            dec_port_q  <= '0;
            dec_flood_q <= 1'b1;
            dec_drop_q  <= 1'b0;
          end else if (bus.read_port_i == in_port_q) begin
            dec_port_q  <= '0;
            dec_flood_q <= 1'b0;
            dec_drop_q  <= 1'b1;
          end else begin
            dec_port_q  <= bus.read_port_i;
            dec_flood_q <= 1'b0;
            dec_drop_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready_o      = in_ready;
  assign bus.learn_req_o     = learn_req;
  assign bus.learn_address_o = src_q;
  assign bus.learn_port_o    = in_port_q;
  assign bus.read_req_o      = read_req;
  assign bus.read_address_o  = dst_q;
  assign bus.dec_valid_o     = dec_valid;
  assign bus.dec_port_o      = dec_valid ? dec_port_q : '0;
  assign bus.dec_flood_o     = dec_valid & dec_flood_q;
  assign bus.dec_drop_o      = dec_valid & dec_drop_q;
  assign runt_cnt_o          = runt_cnt_q;
endmodule

// File: doc/mac_lookup_ctrl.md
Name: mac_lookup_ctrl

Overview:
Ingress header front-end that sits directly upstream of address_table. It consumes one byte stream from the ingress mux and captures the destination and source MAC addresses. It issues the source-learn and destination-read requests to address_table, then presents one forwarding decision per frame (unicast port, flood, or drop) to the downstream queue manager. Frame payload bytes are accepted and discarded here; the data path copy is elsewhere.

Parameters:
NUM_PORTS, 4, number of switch ports; PORT_W = $clog2(NUM_PORTS)
CNT_W, 16, width of the saturating runt-frame counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
in_valid_i  in  1  ingress byte valid
in_ready_o  out  1  ingress byte accepted when in_valid_i && in_ready_o
in_data_i  in  8  ingress byte; first byte of frame = dst[47:40]
in_last_i  in  1  marks final byte of frame
in_port_i  in  PORT_W  ingress port id, sampled on byte 0
learn_req_o  out  1  one-cycle learn pulse to address_table
learn_address_o  out  48  source MAC
learn_port_o  out  PORT_W  ingress port of the frame
read_req_o  out  1  one-cycle lookup pulse to address_table
read_address_o  out  48  destination MAC
read_port_i  in  PORT_W  lookup result port
read_port_valid_i  in  1  lookup hit
dec_valid_o  out  1  decision valid
dec_ready_i  in  1  downstream accepts decision
dec_port_o  out  PORT_W  egress port (valid when !dec_flood_o && !dec_drop_o)
dec_flood_o  out  1  send to all ports except ingress
dec_drop_o  out  1  discard frame (destination is on the ingress port)
runt_cnt_o  out  CNT_W  frames ended before byte 12; saturates at all-ones

Behaviour:
- Reset (rst=1 at posedge): state IDLE; all outputs 0 except in_ready_o=1; byte counter 0; dst/src regs 0; runt_cnt_o=0. Reset mid-frame abandons the frame with no learn, no decision and no count.
- States: HDR, LEARN, LOOKUP, WAIT_RSP, DECIDE, DRAIN. IDLE is HDR with count 0.
- HDR: in_ready_o=1. Byte counter 0..11 counts accepted bytes. Bytes 0-5 shift into dst[47:0], MSB first; bytes 6-11 shift into src. in_port_i is latched on byte 0.
- Runt: in_last_i on any byte 0..10 -> runt_cnt_o+1 (saturating), counter cleared, stay HDR, no requests issued.
- Byte 11 accepted -> LEARN; record whether in_last_i was set (eof_seen). in_ready_o=0 from LEARN through DECIDE.
- LEARN (1 cycle): learn_req_o=1 unless src[40]=1 (multicast source is never learned). Then -> LOOKUP.
- LOOKUP (1 cycle): if dst[40]=1 (includes broadcast FF:FF:FF:FF:FF:FF), no read is issued, flood=1, and the state goes directly to DECIDE. Otherwise read_req_o=1, then -> WAIT_RSP.
- WAIT_RSP (1 cycle): sample read_port_i/read_port_valid_i, one cycle after the read_req_o pulse.
  - Miss -> flood.
  - Hit with port == latched ingress -> drop.
  - Otherwise -> unicast to read_port_i.
- DECIDE: dec_valid_o=1 and dec_* held stable until dec_ready_i. Exactly one of {unicast, flood, drop}; dec_port_o=0 when flood or drop. On handshake: eof_seen -> HDR; else -> DRAIN.
- DRAIN: in_ready_o=1; accepted bytes are discarded; in_last_i accepted -> HDR.
- Addresses and learn port are held stable from LEARN through DECIDE. learn_req_o and read_req_o are never asserted in the same cycle.
- Header-to-decision latency is fixed, counted from the byte-11 accept edge:
  - unicast or miss: dec_valid_o rises 4 cycles later (LEARN, LOOKUP, WAIT_RSP, DECIDE);
  - multicast destination: 3 cycles later.
- Back-to-back frames: the first byte of the next frame may be accepted in the cycle after the previous in_last_i acceptance.

Test Plan:
- Reset with in_valid_i held high → all outputs 0, in_ready_o=1. Then send a 64-byte frame dst=00:00:00:00:10:05, src=00:00:00:00:10:01, port 2, table miss → learn pulse with addr 0x000000001001 port 2, read pulse with 0x000000001005, then dec_flood_o=1 with dec_port_o=0, and DRAIN consumes 52 bytes.
- Same dst, table returns hit with port 1 (ingress 2) → dec_port_o=1, flood=0, drop=0; dec_valid_o rises exactly 4 cycles after the byte-11 accept.
- Table hit with port 2 equal to ingress 2 → dec_drop_o=1; hold dec_ready_i=0 for 5 cycles → outputs stable and in_ready_o=0 throughout.
- dst=FF:FF:FF:FF:FF:FF and src=01:00:5E:00:00:01 → no learn_req_o, no read_req_o, dec_flood_o=1 after 3 cycles.
- 8-byte frame followed immediately by a 12-byte frame ending on byte 11 → runt_cnt_o=1. The second frame yields a decision and returns to HDR with no DRAIN. 65537 runts in a row → runt_cnt_o saturates at 0xFFFF.
- Assert rst at byte 7 of a frame → no learn, no decision, runt_cnt_o unchanged. The next full frame is parsed correctly.
